// File: rtl/instruction_queue_issue.sv
// Instruction queue that expands each pushed entry into copy_count issue slots,
// handing out up to ISSUE_WIDTH copies per cycle with strided per-copy addresses.
module instruction_queue_issue #(
    parameter int LOG_SUPERSCALAR_WIDTH = 3,
    parameter int LOG_QUEUE_DEPTH       = 3,
    parameter int ISSUE_WIDTH           = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              queue_we,
    input  logic [1:0]                        queue_instr_type,
    input  logic [LOG_SUPERSCALAR_WIDTH:0]    queue_copy_count,
    input  logic [8:0]                        queue_arith_instr,
    input  logic [2:0]                        queue_ram_instr,
    input  logic [6:0]                        queue_ld_st_instr,
    input  logic [17:0]                       cache_addr,
    input  logic [17:0]                       main_mem_addr,
    input  logic [17:0]                       d_cache_addr,
    input  logic [17:0]                       d_main_mem_addr,
    output logic                              queue_full,
    output logic                              queue_empty,
    output logic [ISSUE_WIDTH-1:0]            issue_valid,
    input  logic                              issue_ready,
    output logic [ISSUE_WIDTH*21-1:0]         issue_instr,
    output logic [ISSUE_WIDTH*18-1:0]         issue_cache_addr,
    output logic [ISSUE_WIDTH*18-1:0]         issue_main_mem_addr,
    output logic                              overflow_error
);

    localparam int CW    = LOG_SUPERSCALAR_WIDTH + 1;
    localparam int PW    = LOG_QUEUE_DEPTH;
    localparam int DEPTH = 1 << LOG_QUEUE_DEPTH;
    localparam int AW    = 18;
    localparam int IB    = 21;
    localparam logic [CW-1:0] SW_C    = CW'(1 << LOG_SUPERSCALAR_WIDTH);
    localparam logic [CW-1:0] ISSUE_C = CW'(ISSUE_WIDTH);

    function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
        return (c > SW_C) ? SW_C : c;
    endfunction

    // Only valid lanes matter, and their index k+j stays below SW, so CW bits suffice.
    function automatic logic [AW-1:0] lane_addr(input logic [AW-1:0] base,
                                                input logic [AW-1:0] stride,
                                                input logic [CW-1:0] idx);
        return base + AW'(idx) * stride;
    endfunction

    logic [IB-1:0] mem_payload [DEPTH];
    logic [CW-1:0] mem_count   [DEPTH];
    logic [AW-1:0] mem_ca      [DEPTH];
    logic [AW-1:0] mem_ma      [DEPTH];
    logic [AW-1:0] mem_dc      [DEPTH];
    logic [AW-1:0] mem_dm      [DEPTH];

    logic [PW-1:0] head, tail;
    logic [PW:0]   occ;
    logic [CW-1:0] k;

    logic          push, load, pop, last_group;
    logic [CW-1:0] remain, take;

    logic [ISSUE_WIDTH-1:0]    vld_p0;
    logic [ISSUE_WIDTH*IB-1:0] instr_p0;
    logic [ISSUE_WIDTH*AW-1:0] caddr_p0, maddr_p0;

    assign queue_full  = (occ == (PW+1)'(DEPTH));
    assign queue_empty = (occ == '0) && (issue_valid == '0);
    assign push        = queue_we && !queue_full;
    assign load        = ((issue_valid == '0) || issue_ready) && (occ != '0);
    assign pop         = load && last_group;

    // Stage p0: expand the head entry into lane candidates
    always_comb begin
        remain     = mem_count[head] - k;
        last_group = (remain <= ISSUE_C);
        take       = last_group ? remain : ISSUE_C;
        vld_p0     = '0;
        instr_p0   = '0;
        caddr_p0   = '0;
        maddr_p0   = '0;
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            vld_p0[j]                = (CW'(j) < take);
            instr_p0[j*IB +: IB]     = mem_payload[head];
            caddr_p0[j*AW +: AW]     = lane_addr(mem_ca[head], mem_dc[head], k + CW'(j));
            maddr_p0[j*AW +: AW]     = lane_addr(mem_ma[head], mem_dm[head], k + CW'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_payload[tail] <= {queue_instr_type, queue_arith_instr, queue_ram_instr, queue_ld_st_instr};
            mem_count[tail]   <= clamp_count(queue_copy_count);
            mem_ca[tail]      <= cache_addr;
            mem_ma[tail]      <= main_mem_addr;
            mem_dc[tail]      <= d_cache_addr;
            mem_dm[tail]      <= d_main_mem_addr;
        end
    end

    // Stage p1: queue bookkeeping and the registered issue lanes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head                <= '0;
            tail                <= '0;
            occ                 <= '0;
            k                   <= '0;
            overflow_error      <= 1'b0;
            issue_valid         <= '0;
            issue_instr         <= '0;
            issue_cache_addr    <= '0;
            issue_main_mem_addr <= '0;
        end else begin
            if (push)
                tail <= tail + PW'(1);
            if (pop)
                head <= head + PW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (PW+1)'(1);
                2'b01:   occ <= occ - (PW+1)'(1);
                default: occ <= occ;
            endcase
            if (queue_we && queue_full)
                overflow_error <= 1'b1;
            if (load) begin
                k                   <= last_group ? '0 : k + take;
                issue_valid         <= vld_p0;
                issue_instr         <= instr_p0;
                issue_cache_addr    <= caddr_p0;
                issue_main_mem_addr <= maddr_p0;
            end else if (issue_ready) begin
                issue_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_queue_issue.sv
// Bench for instruction_queue_issue: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_instruction_queue_issue;

    localparam int IW    = 3;
    localparam int DEPTH = 8;
    localparam int SW    = 8;

    logic        clk, reset, queue_we, issue_ready;
    logic [1:0]  queue_instr_type;
    logic [3:0]  queue_copy_count;
    logic [8:0]  queue_arith_instr;
    logic [2:0]  queue_ram_instr;
    logic [6:0]  queue_ld_st_instr;
    logic [17:0] cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr;
    logic        queue_full, queue_empty, overflow_error;
    logic [IW-1:0]    issue_valid;
    logic [IW*21-1:0] issue_instr;
    logic [IW*18-1:0] issue_cache_addr, issue_main_mem_addr;

    instruction_queue_issue #(.LOG_SUPERSCALAR_WIDTH(3), .LOG_QUEUE_DEPTH(3), .ISSUE_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .queue_we(queue_we), .queue_instr_type(queue_instr_type),
        .queue_copy_count(queue_copy_count), .queue_arith_instr(queue_arith_instr),
        .queue_ram_instr(queue_ram_instr), .queue_ld_st_instr(queue_ld_st_instr),
        .cache_addr(cache_addr), .main_mem_addr(main_mem_addr), .d_cache_addr(d_cache_addr),
        .d_main_mem_addr(d_main_mem_addr), .queue_full(queue_full), .queue_empty(queue_empty),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
        .issue_cache_addr(issue_cache_addr), .issue_main_mem_addr(issue_main_mem_addr),
        .overflow_error(overflow_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] instr;
        int          cnt;
        logic [17:0] ca, ma, dc, dm;
    } ent_t;

    ent_t             mq[$];
    int               mk;
    logic [IW-1:0]    m_valid;
    logic [IW*21-1:0] m_instr;
    logic [IW*18-1:0] m_ca, m_ma;
    logic             m_ovf;
    int               n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        mq.delete();
        mk      = 0;
        m_valid = '0;
        m_ovf   = 1'b0;
    endfunction

    // Reference: what one rising edge does, given the inputs currently applied.
    function automatic void model_edge();
        ent_t e;
        int   r, n;
        bit   full, ld;
        full = (mq.size() == DEPTH);
        ld   = ((m_valid == 0) || issue_ready) && (mq.size() > 0);
        if (ld) begin
            e = mq[0];
            r = e.cnt - mk;
            n = (r < IW) ? r : IW;
            m_valid = '0;
            for (int j = 0; j < IW; j++) begin
                if (j < n) begin
                    m_valid[j]        = 1'b1;
                    m_instr[j*21+:21] = e.instr;
                    m_ca[j*18+:18]    = 18'(32'(e.ca) + (mk + j) * 32'(e.dc));
                    m_ma[j*18+:18]    = 18'(32'(e.ma) + (mk + j) * 32'(e.dm));
                end
            end
            mk += n;
            if (mk == e.cnt) begin
                void'(mq.pop_front());
                mk = 0;
            end
        end else if (issue_ready) begin
            m_valid = '0;
        end
        if (queue_we) begin
            if (full) m_ovf = 1'b1;
            else begin
                e.instr = {queue_instr_type, queue_arith_instr, queue_ram_instr, queue_ld_st_instr};
                e.cnt   = (int'(queue_copy_count) > SW) ? SW : int'(queue_copy_count);
                e.ca = cache_addr; e.ma = main_mem_addr; e.dc = d_cache_addr; e.dm = d_main_mem_addr;
                mq.push_back(e);
            end
        end
    endfunction

    task automatic check_model();
        chk("valid", issue_valid, m_valid);
        chk("full", queue_full, mq.size() == DEPTH);
        chk("empty", queue_empty, (mq.size() == 0) && (m_valid == 0));
        chk("overflow", overflow_error, m_ovf);
        for (int j = 0; j < IW; j++) begin
            if (m_valid[j]) begin
                chk("lane_instr", issue_instr[j*21+:21], m_instr[j*21+:21]);
                chk("lane_caddr", issue_cache_addr[j*18+:18], m_ca[j*18+:18]);
                chk("lane_maddr", issue_main_mem_addr[j*18+:18], m_ma[j*18+:18]);
            end
        end
    endtask

    task automatic step(input bit do_chk);
        model_edge();
        @(posedge clk);
        #1;
        if (do_chk) check_model();
    endtask

    task automatic set_push(input bit we, input int cnt, input logic [17:0] ca, input logic [17:0] dc);
        queue_we          = we;
        queue_copy_count  = 4'(cnt);
        cache_addr        = ca;
        main_mem_addr     = ca;
        d_cache_addr      = dc;
        d_main_mem_addr   = dc;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        queue_we = 1'b0;
        issue_ready = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic chk_lanes(input string nm, input logic [2:0] ev,
                             input logic [17:0] a0, input logic [17:0] a1, input logic [17:0] a2);
        logic [17:0] ea [3];
        ea[0] = a0; ea[1] = a1; ea[2] = a2;
        chk({nm, "_valid"}, issue_valid, ev);
        for (int j = 0; j < IW; j++) begin
            if (ev[j]) chk({nm, "_addr"}, issue_cache_addr[j*18+:18], ea[j]);
        end
    endtask

    typedef struct {
        bit          we;
        int          cnt;
        logic [17:0] ca, dc;
        bit          rdy;
        logic [2:0]  ev;
        logic [17:0] a0, a1, a2;
        bit          ee;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 5, 18'd100, 18'd4, 1'b1, 3'b000, 18'd0, 18'd0, 18'd0, 1'b0};
        tbl[1]  = '{1'b0, 0, 18'd0, 18'd0, 1'b1, 3'b111, 18'd100, 18'd104, 18'd108, 1'b0};
        tbl[2]  = '{1'b0, 0, 18'd0, 18'd0, 1'b1, 3'b011, 18'd112, 18'd116, 18'd0, 1'b0};
        tbl[3]  = '{1'b0, 0, 18'd0, 18'd0, 1'b1, 3'b000, 18'd0, 18'd0, 18'd0, 1'b1};
        tbl[4]  = '{1'b1, 2, 18'h3FFFF, 18'd1, 1'b1, 3'b000, 18'd0, 18'd0, 18'd0, 1'b0};
        tbl[5]  = '{1'b0, 0, 18'd0, 18'd0, 1'b1, 3'b011, 18'h3FFFF, 18'h00000, 18'd0, 1'b0};
        tbl[6]  = '{1'b0, 0, 18'd0, 18'd0, 1'b1, 3'b000, 18'd0, 18'd0, 18'd0, 1'b1};
        tbl[7]  = '{1'b1, 0, 18'd50, 18'd1, 1'b1, 3'b000, 18'd0, 18'd0, 18'd0, 1'b0};
        tbl[8]  = '{1'b1, 1, 18'd7, 18'd3, 1'b1, 3'b000, 18'd0, 18'd0, 18'd0, 1'b0};
        tbl[9]  = '{1'b0, 0, 18'd0, 18'd0, 1'b1, 3'b001, 18'd7, 18'd0, 18'd0, 1'b0};
        tbl[10] = '{1'b0, 0, 18'd0, 18'd0, 1'b1, 3'b000, 18'd0, 18'd0, 18'd0, 1'b1};

        reset = 1'b1; issue_ready = 1'b0;
        queue_instr_type = 2'd2; queue_arith_instr = 9'h0A5; queue_ram_instr = 3'b101; queue_ld_st_instr = 7'h33;
        set_push(1'b0, 0, 18'd0, 18'd0);

        // Asynchronous reset values
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", issue_valid, 3'b000);
        chk("rst_empty", queue_empty, 1'b1);
        chk("rst_full", queue_full, 1'b0);
        chk("rst_overflow", overflow_error, 1'b0);
        chk("rst_instr", issue_instr, 63'd0);
        chk("rst_caddr", issue_cache_addr, 54'd0);
        chk("rst_maddr", issue_main_mem_addr, 54'd0);
        do_reset();

        // Directed vectors: expansion, address wrap, zero-copy entry
        for (int i = 0; i < 11; i++) begin
            set_push(tbl[i].we, tbl[i].cnt, tbl[i].ca, tbl[i].dc);
            issue_ready = tbl[i].rdy;
            step(1'b0);
            chk_lanes($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].a0, tbl[i].a1, tbl[i].a2);
            chk($sformatf("tbl%0d_empty", i), queue_empty, tbl[i].ee);
        end

        // Stall hold on a copy-8 entry
        do_reset();
        set_push(1'b1, 8, 18'd0, 18'd10); issue_ready = 1'b0;
        step(1'b1);
        queue_we = 1'b0;
        step(1'b1);
        chk_lanes("stall_first", 3'b111, 18'd0, 18'd10, 18'd20);
        for (int c = 0; c < 3; c++) begin
            step(1'b1);
            chk_lanes("stall_hold", 3'b111, 18'd0, 18'd10, 18'd20);
        end
        issue_ready = 1'b1;
        step(1'b1);
        chk_lanes("stall_g2", 3'b111, 18'd30, 18'd40, 18'd50);
        step(1'b1);
        chk_lanes("stall_g3", 3'b011, 18'd60, 18'd70, 18'd0);
        step(1'b1);
        chk_lanes("stall_done", 3'b000, 18'd0, 18'd0, 18'd0);

        // Fill to full, drop a ninth push, then drain in order
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_push(1'b1, 4, 18'(i * 1000), 18'(i + 1));
            queue_arith_instr = 9'(i);
            step(1'b1);
            if (i == 7) chk("ovf_full", queue_full, 1'b1);
        end
        chk("ovf_flag", overflow_error, 1'b1);
        chk("ovf_still_full", queue_full, 1'b1);
        queue_we = 1'b0; issue_ready = 1'b1;
        for (int c = 0; c < 24; c++) step(1'b1);
        chk("ovf_drained", queue_empty, 1'b1);

        // Reset during the second group of a copy-8 entry
        do_reset();
        set_push(1'b1, 8, 18'd0, 18'd5); issue_ready = 1'b1;
        step(1'b1);
        queue_we = 1'b0;
        step(1'b1);
        step(1'b1);
        chk_lanes("rstmid_g2", 3'b111, 18'd15, 18'd20, 18'd25);
        #2 reset = 1'b0;
        #1;
        model_clear();
        chk("rstmid_valid", issue_valid, 3'b000);
        chk("rstmid_empty", queue_empty, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(1'b1);
            chk("rstmid_quiet", issue_valid, 3'b000);
        end

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            queue_we          = ($urandom_range(0, 1) == 1);
            issue_ready       = ($urandom_range(0, 2) != 0);
            queue_copy_count  = 4'($urandom_range(0, 15));
            queue_instr_type  = 2'($urandom);
            queue_arith_instr = 9'($urandom);
            queue_ram_instr   = 3'($urandom);
            queue_ld_st_instr = 7'($urandom);
            cache_addr        = 18'($urandom);
            main_mem_addr     = 18'($urandom);
            d_cache_addr      = 18'($urandom);
            d_main_mem_addr   = 18'($urandom);
            step(1'b1);
        end
        queue_we = 1'b0; issue_ready = 1'b1;
        for (int c = 0; c < 40; c++) step(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_queue_issue.md
INSTRUCTION_QUEUE_ISSUE -- requirements
Module: instruction_queue_issue

Interface
REQ-001 SHALL have parameter LOG_SUPERSCALAR_WIDTH, default 3: copy-count field width is LOG_SUPERSCALAR_WIDTH+1 bits, maximum copies SW = 2^LOG_SUPERSCALAR_WIDTH.
REQ-002 SHALL have parameter LOG_QUEUE_DEPTH, default 3: queue holds DEPTH = 2^LOG_QUEUE_DEPTH entries.
REQ-003 SHALL have parameter ISSUE_WIDTH, default 3: the number of issue lanes.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 queue_we  in  1  push strobe from the control unit.
REQ-007 queue_instr_type  in  2  instruction type of the pushed entry.
REQ-008 queue_copy_count  in  LOG_SUPERSCALAR_WIDTH+1  number of copies to expand.
REQ-009 queue_arith_instr  in  9  arithmetic payload.
REQ-010 queue_ram_instr  in  3  RAM payload: {is_write, cache_slot}.
REQ-011 queue_ld_st_instr  in  7  load/store payload.
REQ-012 cache_addr, main_mem_addr  in  18 each  base address for copy 0.
REQ-013 d_cache_addr, d_main_mem_addr  in  18 each  per-copy address stride.
REQ-014 queue_full  out  1  occupancy == DEPTH.
REQ-015 queue_empty  out  1  occupancy == 0 and no lane valid.
REQ-016 issue_valid  out  ISSUE_WIDTH  per-lane valid; always a contiguous mask from lane 0.
REQ-017 issue_ready  in  1  consumer accepts every valid lane this cycle.
REQ-018 issue_instr  out  ISSUE_WIDTH*21  per lane: {type, arith, ram, ld_st}, with lane 0 in the LSBs.
REQ-019 issue_cache_addr, issue_main_mem_addr  out  ISSUE_WIDTH*18  per-lane addresses.
REQ-020 overflow_error  out  1  sticky; set by a dropped push.

Function
REQ-021 Push handling:
- On a clk edge with queue_we=1 and queue_full=0, the block SHALL write all input fields into the tail slot and increment the tail pointer (mod DEPTH).
- A clamp SHALL apply on write: copy_count > SW is stored as SW.
REQ-022 Full push: a push with queue_full=1 SHALL be dropped and SHALL set overflow_error. queue_full is evaluated on registered occupancy, so this applies even if a pop occurs in the same cycle.
REQ-023 Output register load condition: the output register SHALL load when (issue_valid==0 or issue_ready==1) and occupancy > 0.
REQ-024 Lane content on load, for head entry with issued-so-far index k and remaining count R:
- Lanes j < min(R, ISSUE_WIDTH) SHALL be valid.
- issue_cache_addr[j] = cache_addr + (k+j)*d_cache_addr, truncated mod 2^18.
- issue_main_mem_addr[j] is computed identically from main_mem_addr and d_main_mem_addr.
- issue_instr[j] = the entry payload.
REQ-025 Index update after a load: k += min(R, ISSUE_WIDTH). When R reaches 0, the head entry SHALL be popped (head+1 mod DEPTH, occupancy-1) and k SHALL be reset to 0.
REQ-026 Lane packing: each load SHALL draw lanes from one entry only; entries are never merged into one issue group.
REQ-027 Zero copies: an entry with copy_count 0 SHALL be popped in one load cycle with issue_valid=0 and no issue.
REQ-028 Stall: when issue_valid != 0 and issue_ready = 0, all issue outputs SHALL hold their values exactly.
REQ-029 Drain: when issue_ready=1 and occupancy=0, issue_valid SHALL go to 0 on the next edge. Data fields hold their last values.
REQ-030 Latency: an entry pushed at edge N into an empty block with issue_ready=1 SHALL appear on the lanes after edge N+1.
REQ-031 Occupancy on simultaneous push and pop: occupancy SHALL be unchanged, and both pointers advance.
REQ-032 Arithmetic rules: address arithmetic is unsigned 18-bit with wrap-around. The multiply by k+j uses at most a 4-bit operand.
REQ-033 Ordering: entries SHALL issue in push order, and copies within an entry in ascending k.

Reset
REQ-034 While reset=0, the block SHALL asynchronously force:
- outputs: issue_valid=0, issue_instr=0, issue addresses=0, overflow_error=0, queue_full=0, queue_empty=1;
- internal state: occupancy, pointers and k all to 0.
REQ-035 Reset asserted mid-expansion SHALL discard all entries and partial copies. Operation resumes on the first edge after reset=1.

Verification
REQ-036 Basic expansion: push ld_st, copy 5, cache_addr 100, d 4, ready=1 -> lanes 100/104/108 (valid 111), then 112/116 (valid 011), then valid 000 with queue_empty=1.
REQ-037 Stall hold: push copy 8 with ready=0 for 3 cycles -> lanes 0,d,2d held stable for 3 cycles. With ready=1 the sequence continues 3d,4d,5d, then 6d,7d.
REQ-038 Overflow: 8 pushes with ready=0 -> queue_full=1. A 9th push is dropped, overflow_error=1, and the 8 original entries issue intact in order.
REQ-039 Wrap-around: cache_addr 18'h3FFFF, d 1, copy 2 -> lanes 3FFFF, 00000.
REQ-040 Zero copies: push copy 0 then copy 1 (addr 7) -> only one issue group: valid 001, addr 7.
REQ-041 Reset mid-operation: assert reset during the second group of a copy-8 entry -> issue_valid=0 immediately. After release, queue_empty=1 and there is no further issue.
